// File: rtl/tile_renderer_if.sv
// Map RAM read bus between tile_renderer and the game-map RAM.
// map_addr: read address (master drives); map_data: tile code, valid 1 clock later.
interface tile_renderer_if #(
    parameter int ADDR_W = 9,
    parameter int CODE_W = 3
);
    logic [ADDR_W-1:0] map_addr;
    logic [CODE_W-1:0] map_data;

    modport master (
        output map_addr,
        input  map_data
    );

    modport slave (
        input  map_addr,
        output map_data
    );
endinterface

// File: rtl/tile_renderer.sv
// Tile/sprite pixel stage: map lookup, robot overlay, 2-tick aligned RGB/sync.
// Ports: clock_50, reset_key[0] (async low), p_tick, pixel_x/y, video_on,
// hs_in, vs_in, robot_col/row, map_bus (RAM read), vga_r/g/b, vga_hs/vs, vga_blank_n.
module tile_renderer #(
    parameter int TILE_SHIFT = 5,
    parameter int MAP_COLS   = 20,
    parameter int MAP_ROWS   = 15,
    parameter int ADDR_W     = 9,
    parameter int CODE_W     = 3
) (
    input  logic             clock_50,
    input  logic [3:0]       reset_key,
    input  logic             p_tick,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [4:0]       robot_col,
    input  logic [3:0]       robot_row,
    tile_renderer_if.master  map_bus,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n
);

    localparam int CW = 10 - TILE_SHIFT;
    localparam int TS = TILE_SHIFT;

    // Sprite occupies the centre half of the tile (8..23 for 32-pixel tiles).
    localparam logic [TS-1:0] SPR_LO = TS'(1 << (TS - 2));
    localparam logic [TS-1:0] SPR_HI = TS'((1 << TS) - 1 - (1 << (TS - 2)));

    // First line of vertical blanking: robot position is sampled here.
    localparam logic [9:0] VBL_Y = 10'(MAP_ROWS << TS);

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_ROBOT  = 24'hFFFF00;
    localparam logic [23:0] C_BORDER = 24'h202020;
    localparam logic [23:0] C_WALL   = 24'h808080;
    localparam logic [23:0] C_CLEAN  = 24'h0040FF;
    localparam logic [23:0] C_DIRTY  = 24'h804000;
    localparam logic [23:0] C_DONE   = 24'h00C000;
    localparam logic [23:0] C_BAD    = 24'hFF00FF;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        logic [TS-1:0] ox;
        logic [TS-1:0] oy;
        logic          vid;
        logic          hs;
        logic          vs;
    } s1_t;

    logic rst_n;
    assign rst_n = reset_key[0];

    logic unused_keys;
    assign unused_keys = &{1'b0, reset_key[3:1]};

    // ---- stage 1: tile address and in-tile offsets ----
    logic [CW-1:0] col_c;
    logic [CW-1:0] row_c;
    logic [15:0]   lin_c;
    logic          in_map_c;

    assign col_c    = pixel_x[9:TS];
    assign row_c    = pixel_y[9:TS];
    assign lin_c    = 16'(row_c) * 16'(MAP_COLS) + 16'(col_c);
    assign in_map_c = (col_c < CW'(MAP_COLS)) && (row_c < CW'(MAP_ROWS));

    s1_t s1;

    always_ff @(posedge clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '{col: '0, row: '0, ox: '0, oy: '0,
                    vid: 1'b0, hs: 1'b1, vs: 1'b1};
            map_bus.map_addr <= '0;
        end else if (p_tick) begin
            s1.col <= col_c;
            s1.row <= row_c;
            s1.ox  <= pixel_x[TS-1:0];
            s1.oy  <= pixel_y[TS-1:0];
            s1.vid <= video_on;
            s1.hs  <= hs_in;
            s1.vs  <= vs_in;
            // Never present an address outside the map, even during blanking.
            if (video_on && in_map_c)
                map_bus.map_addr <= ADDR_W'(lin_c);
            else
                map_bus.map_addr <= '0;
        end
    end

    // ---- robot latch: updated once per frame so the sprite never tears ----
    logic [4:0] rob_col;
    logic [3:0] rob_row;

    always_ff @(posedge clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            rob_col <= 5'd31;
            rob_row <= 4'd15;
        end else if (p_tick && pixel_x == 10'd0 && pixel_y == VBL_Y) begin
            rob_col <= robot_col;
            rob_row <= robot_row;
        end
    end

    // ---- stage 2: colour select ----
    logic        rob_ok;
    logic        rob_hit;
    logic        border;
    logic [23:0] rgb_nx;

    assign rob_ok  = (rob_col < 5'(MAP_COLS)) && (rob_row < 4'(MAP_ROWS));
    assign rob_hit = rob_ok
                  && s1.col == CW'(rob_col)
                  && s1.row == CW'(rob_row)
                  && s1.ox >= SPR_LO && s1.ox <= SPR_HI
                  && s1.oy >= SPR_LO && s1.oy <= SPR_HI;
    assign border  = (s1.ox == '0) || (s1.oy == '0);

    always_comb begin
        rgb_nx = C_BLACK;
        if (!s1.vid) begin
            rgb_nx = C_BLACK;
        end else if (rob_hit) begin
            rgb_nx = C_ROBOT;
        end else if (border && map_bus.map_data != '0) begin
            rgb_nx = C_BORDER;
        end else begin
            case (map_bus.map_data)
                CODE_W'(0): rgb_nx = C_BLACK;
                CODE_W'(1): rgb_nx = C_WALL;
                CODE_W'(2): rgb_nx = C_CLEAN;
                CODE_W'(3): rgb_nx = C_DIRTY;
                CODE_W'(4): rgb_nx = C_DONE;
                default:    rgb_nx = C_BAD;
            endcase
        end
    end

    always_ff @(posedge clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (p_tick) begin
            vga_r       <= rgb_nx[23:16];
            vga_g       <= rgb_nx[15:8];
            vga_b       <= rgb_nx[7:0];
            vga_hs      <= s1.hs;
            vga_vs      <= s1.vs;
            vga_blank_n <= s1.vid;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: vector table plus reset/hold sequences.
// Drives pixels one p_tick at a time and models the map RAM.
module tb_tile_renderer;

    logic        clock_50 = 1'b0;
    logic [3:0]  reset_key;
    logic        p_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hs_in;
    logic        vs_in;
    logic [4:0]  robot_col;
    logic [3:0]  robot_row;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;

    always #10 clock_50 = ~clock_50;

    tile_renderer_if #(.ADDR_W(9), .CODE_W(3)) map_bus ();

    tile_renderer dut (
        .clock_50    (clock_50),
        .reset_key   (reset_key),
        .p_tick      (p_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .robot_col   (robot_col),
        .robot_row   (robot_row),
        .map_bus     (map_bus),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n)
    );

    // Synchronous-read map RAM model
    logic [2:0] mem [0:511];
    always @(posedge clock_50) map_bus.map_data <= mem[map_bus.map_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          x;
        int          y;
        bit          vid;
        bit          hs;
        bit          vs;
        int          rc;
        int          rr;
        int          addr;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int x, input int y, input bit vid, input bit hs,
                       input bit vs, input int rc, input int rr,
                       input int addr, input logic [23:0] rgb);
        vec_t v;
        v = '{x, y, vid, hs, vs, rc, rr, addr, rgb};
        tbl.push_back(v);
    endtask

    // One pixel: inputs valid across exactly one p_tick edge
    task automatic pix(input int x, input int y, input bit vid, input bit hs,
                       input bit vs, input int rc, input int rr);
        @(negedge clock_50);
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        video_on  = vid;
        hs_in     = hs;
        vs_in     = vs;
        robot_col = 5'(rc);
        robot_row = 4'(rr);
        p_tick    = 1'b1;
        @(negedge clock_50);
        p_tick    = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [23:0] rgb,
                           input bit hs, input bit vs, input bit bn);
        chk({tag, "_rgb"}, {8'h0, vga_r, vga_g, vga_b}, {8'h0, rgb});
        chk({tag, "_hs"}, 32'(vga_hs), 32'(hs));
        chk({tag, "_vs"}, 32'(vga_vs), 32'(vs));
        chk({tag, "_bn"}, 32'(vga_blank_n), 32'(bn));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'd0;
        mem[43]  = 3'd2;
        mem[22]  = 3'd1;
        mem[105] = 3'd6;
        mem[21]  = 3'd3;
        mem[299] = 3'd4;
        mem[42]  = 3'd1;
        mem[150] = 3'd1;

        reset_key = 4'b1110;
        p_tick    = 1'b0;
        pixel_x   = '0;
        pixel_y   = '0;
        video_on  = 1'b0;
        hs_in     = 1'b1;
        vs_in     = 1'b1;
        robot_col = 5'd31;
        robot_row = 4'd15;

        // Reset held: ticks must not disturb anything
        pix(100, 70, 1, 1, 1, 31, 15);
        pix(100, 70, 1, 0, 0, 31, 15);
        chk("rst_addr", 32'(map_bus.map_addr), 32'd0);
        chk_out("rst", 24'h000000, 1, 1, 0);
        @(negedge clock_50);
        reset_key = 4'b1111;

        //   x    y   vid hs vs  rc  rr  addr  rgb
        add(  0,   0, 1, 1, 1, 31, 15,   0, 24'h000000);
        add(100,  70, 1, 1, 1, 31, 15,  43, 24'h0040FF);
        add( 64,  32, 1, 1, 1, 31, 15,  22, 24'h202020);
        add( 69,  37, 1, 1, 1, 31, 15,  22, 24'h808080);
        add(165, 165, 1, 1, 1, 31, 15, 105, 24'hFF00FF);
        add( 40,  40, 1, 1, 1, 31, 15,  21, 24'h804000);
        add(639, 479, 1, 1, 1, 31, 15, 299, 24'h00C000);
        add(700,  70, 0, 0, 1, 31, 15,   0, 24'h000000);
        add(100,  70, 1, 1, 1, 31, 15,  43, 24'h0040FF);
        add(104,  72, 1, 1, 1,  3,  2,  43, 24'h0040FF);
        add(  0, 480, 0, 1, 0,  3,  2,   0, 24'h000000);
        add(104,  72, 1, 1, 1,  3,  2,  43, 24'hFFFF00);
        add( 97,  65, 1, 1, 1,  3,  2,  43, 24'h0040FF);
        add(103,  71, 1, 1, 1,  3,  2,  43, 24'h0040FF);
        add(119,  87, 1, 1, 1,  3,  2,  43, 24'hFFFF00);
        add(120,  72, 1, 1, 1,  3,  2,  43, 24'h0040FF);
        add(104,  88, 1, 1, 1,  3,  2,  43, 24'h0040FF);
        add( 72,  72, 1, 1, 1,  3,  2,  42, 24'h808080);
        add(104,  72, 1, 1, 1, 25,  2,  43, 24'hFFFF00);
        add(  0, 480, 0, 1, 0, 25,  2,   0, 24'h000000);
        add(104,  72, 1, 1, 1, 25,  2,  43, 24'h0040FF);
        add(100,  70, 0, 1, 1, 25,  2,   0, 24'h000000);
        add( 96,  70, 1, 1, 1, 25,  2,  43, 24'h202020);
        add(100,  64, 1, 1, 1, 25,  2,  43, 24'h202020);

        // Address shows after one tick; colour/sync of row i after row i+1
        for (int i = 0; i < tbl.size(); i++) begin
            pix(tbl[i].x, tbl[i].y, tbl[i].vid, tbl[i].hs, tbl[i].vs,
                tbl[i].rc, tbl[i].rr);
            chk($sformatf("v%0d_addr", i), 32'(map_bus.map_addr),
                32'(tbl[i].addr));
            if (i > 0)
                chk_out($sformatf("v%0d", i - 1), tbl[i-1].rgb,
                        tbl[i-1].hs, tbl[i-1].vs, tbl[i-1].vid);
        end
        pix(700, 500, 0, 1, 1, 25, 2);
        chk_out($sformatf("v%0d", tbl.size() - 1), tbl[tbl.size()-1].rgb,
                tbl[tbl.size()-1].hs, tbl[tbl.size()-1].vs,
                tbl[tbl.size()-1].vid);

        // Without p_tick everything holds
        pix(100, 70, 1, 1, 1, 25, 2);
        pix(69, 37, 1, 1, 1, 25, 2);
        @(negedge clock_50);
        pixel_x  = 10'd165;
        pixel_y  = 10'd165;
        hs_in    = 1'b0;
        video_on = 1'b0;
        repeat (4) @(negedge clock_50);
        chk("hold_addr", 32'(map_bus.map_addr), 32'd22);
        chk_out("hold", 24'h0040FF, 1, 1, 1);

        // Mid-frame reset pulse
        pix(325, 245, 1, 1, 1, 25, 2);
        chk("pre_addr", 32'(map_bus.map_addr), 32'd150);
        pix(320, 240, 1, 1, 1, 25, 2);
        chk_out("pre", 24'h808080, 1, 1, 1);
        @(posedge clock_50);
        #3 reset_key = 4'b1110;
        #1;
        chk("arst_addr", 32'(map_bus.map_addr), 32'd0);
        chk_out("arst", 24'h000000, 1, 1, 0);
        repeat (2) @(negedge clock_50);
        reset_key = 4'b1111;
        pix(325, 245, 1, 1, 1, 25, 2);
        chk("post1_addr", 32'(map_bus.map_addr), 32'd150);
        chk_out("post1", 24'h000000, 1, 1, 0);
        pix(700, 500, 0, 1, 1, 25, 2);
        chk_out("post2", 24'h808080, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
